layer_deser: RTL and testbench

- Receiver for the valid-qualified serial word stream that drives each network layer. This is the stream a layer-output serializer produces: one word per valid cycle, word 0 first.
- Collects numWords words into a parallel vector and pulses a one-cycle frame-valid.
- Sits at the input of a parallel-consuming stage, such as the max finder or a debug capture port, downstream of any serializing layer FSM.

---
 rtl/layer_deser.sv | 120 ++++++++++++
 tb/tb_layer_deser.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_deser.sv
// layer_deser: valid-qualified serial word stream to parallel frame.
// Collects numWords words (word 0 first) into a shadow buffer and presents the
// completed frame on out_data together with a one-cycle out_valid pulse.
// Optional gap timeout: define LAYER_DESER_TIMEOUT_EN to abort a partial frame
// after timeoutCycles consecutive idle cycles, which pulses frame_err.
module layer_deser #(
  parameter int dataWidth     = 16,
  parameter int numWords      = 16,
  parameter int cntWidth      = $clog2(numWords + 1),
  parameter int timeoutCycles = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [dataWidth-1:0]          in_data,
  output logic                          out_valid,
  output logic [numWords*dataWidth-1:0] out_data,
  output logic                          busy,
  output logic                          frame_err
);

  localparam int                  FrameW  = numWords * dataWidth;
  localparam logic [cntWidth-1:0] LastIdx = cntWidth'(numWords - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t              state;
  logic [cntWidth-1:0] word_cnt;
  logic [FrameW-1:0]   shadow;
  logic [FrameW-1:0]   frame_next;
  logic                last_word;
  logic                timeout;

  // Shadow buffer with the incoming word merged into its slot, so the final
  // word of a frame reaches out_data straight from the sampling edge.
  always_comb begin
    // NOTE: default assignment first, so no path leaves frame_next unassigned
    // and no latch is inferred.
    frame_next = shadow;
    for (int k = 0; k < numWords; k++) begin
      if (word_cnt == cntWidth'(k)) begin
        frame_next[k*dataWidth +: dataWidth] = in_data;
      end
    end
  end

  // In IDLE the counter is 0, so with numWords==1 the first word is also the last.
  assign last_word = in_valid && (word_cnt == LastIdx);

  // Word collection FSM and registered frame outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state, so every register updates
    // from pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the shadow buffer is a plain register bank (not a RAM), so
      // clearing it on reset is cheap and keeps it deterministic.
      state     <= IDLE;
      word_cnt  <= '0;
      shadow    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        shadow <= frame_next;
        if (last_word) begin
          out_valid <= 1'b1;
          out_data  <= frame_next;
          word_cnt  <= '0;
          state     <= IDLE;
        end else begin
          word_cnt <= word_cnt + 1'b1;
          state    <= COLLECT;
        end
      end else if (timeout) begin
        // Abort: drop the partial frame; out_data keeps the last good frame.
        word_cnt <= '0;
        state    <= IDLE;
      end
    end
  end

  assign busy = (state == COLLECT);

`ifdef LAYER_DESER_TIMEOUT_EN
  localparam int GapW = $clog2(timeoutCycles + 1);

  logic [GapW-1:0] gap_cnt;
  logic            frame_err_q;

  // Fires on the timeoutCycles-th consecutive idle cycle of a partial frame.
  assign timeout = (state == COLLECT) && !in_valid &&
                   (gap_cnt == GapW'(timeoutCycles - 1));

  // Idle-gap counter; cleared outside COLLECT, on every word and on abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= timeout;
      if ((state != COLLECT) || in_valid || timeout) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  assign frame_err = frame_err_q;
`else
  // Without the timeout a partial frame waits indefinitely.
  assign timeout   = 1'b0;
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_deser.sv
// Directed testbench for layer_deser (dataWidth=16, numWords=16).
// The timeout scenario runs only when LAYER_DESER_TIMEOUT_EN is defined,
// in which case the DUT is built with timeoutCycles=8.
module tb_layer_deser;

  localparam int DW = 16;
  localparam int NW = 16;
  localparam int FW = DW * NW;
`ifdef LAYER_DESER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [FW-1:0] out_data;
  logic          busy;
  logic          frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_ferr   = 0;

  layer_deser #(
    .dataWidth    (DW),
    .numWords     (NW),
    .timeoutCycles(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (out_valid) n_valid++;
    if (frame_err) n_ferr++;
  end

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [FW-1:0] frame_of(input logic [DW-1:0] base);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NW; k++) f[k*DW +: DW] = base + DW'(k);
    return f;
  endfunction

  // Hard bound so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int f0;
    int pulse_idx[$];
    logic [FW-1:0] f_prev;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset held 3 cycles with in_valid toggling: all outputs stay low.
    for (int i = 0; i < 3; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = DW'(16'h5A00 + i);
      step();
      check("rst_out_valid", FW'(out_valid), FW'(0));
      check("rst_out_data",  out_data,       FW'(0));
      check("rst_busy",      FW'(busy),      FW'(0));
      check("rst_frame_err", FW'(frame_err), FW'(0));
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(2);

    // Contiguous frame 0x0001..0x0010.
    v0 = n_valid;
    for (int i = 0; i < NW; i++) begin
      send_word(DW'(i + 1));
      if (i == 0)  check("contig_busy_w0", FW'(busy), FW'(1));
      if (i == 14) check("contig_no_early_valid", FW'(out_valid), FW'(0));
    end
    check("contig_valid",  FW'(out_valid), FW'(1));
    check("contig_busy",   FW'(busy),      FW'(0));
    check("contig_word0",  FW'(out_data[15:0]),    FW'(16'h0001));
    check("contig_word15", FW'(out_data[255:240]), FW'(16'h0010));
    check("contig_frame",  out_data, frame_of(16'h0001));
    idle(1);
    check("contig_pulse_1cyc", FW'(out_valid), FW'(0));
    check("contig_hold",       out_data, frame_of(16'h0001));
    check("contig_pulses", FW'(n_valid - v0), FW'(1));

    // Gapped frame: 5 idle cycles after words 3 and 9.
    v0 = n_valid;
    f0 = n_ferr;
    for (int i = 0; i < NW; i++) begin
      send_word(DW'(i + 1));
      if (i == 2 || i == 8) begin
        idle(5);
        check("gap_busy_held", FW'(busy),      FW'(1));
        check("gap_no_valid",  FW'(out_valid), FW'(0));
      end
    end
    check("gap_valid", FW'(out_valid), FW'(1));
    check("gap_frame", out_data, frame_of(16'h0001));
    idle(1);
    check("gap_pulses", FW'(n_valid - v0), FW'(1));
    check("gap_no_err", FW'(n_ferr - f0),  FW'(0));

    // Back-to-back: 32 consecutive words 0x0100..0x011F.
    v0 = n_valid;
    for (int i = 0; i < 2 * NW; i++) begin
      send_word(DW'(16'h0100 + i));
      in_valid = 1'b1;  // keep the strobe continuous between words
      if (out_valid) pulse_idx.push_back(i);
      if (i == NW)         check("b2b_busy_next",   FW'(busy), FW'(1));
      if (i == 2 * NW - 2) check("b2b_first_holds", out_data, frame_of(16'h0100));
    end
    in_valid = 1'b0;
    check("b2b_frame2", out_data, frame_of(16'h0110));
    check("b2b_f2_w0",  FW'(out_data[15:0]),    FW'(16'h0110));
    check("b2b_f2_w15", FW'(out_data[255:240]), FW'(16'h011F));
    idle(1);
    check("b2b_pulses", FW'(n_valid - v0), FW'(2));
    if (pulse_idx.size() == 2) begin
      check("b2b_first_at",  FW'(pulse_idx[0]),                FW'(NW - 1));
      check("b2b_spacing",   FW'(pulse_idx[1] - pulse_idx[0]), FW'(NW));
    end else begin
      check("b2b_pulse_count_seen", FW'(pulse_idx.size()), FW'(2));
    end

    // Reset mid-frame: 7 words discarded, then a clean frame 0xA000..0xA00F.
    v0 = n_valid;
    f0 = n_ferr;
    for (int i = 0; i < 7; i++) send_word(DW'(16'hB000 + i));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", FW'(busy),  FW'(0));
    check("mid_rst_data", out_data,   FW'(0));
    for (int i = 0; i < NW; i++) send_word(DW'(16'hA000 + i));
    check("mid_rst_valid", FW'(out_valid), FW'(1));
    check("mid_rst_frame", out_data, frame_of(16'hA000));
    check("mid_rst_w0",    FW'(out_data[15:0]), FW'(16'hA000));
    idle(1);
    check("mid_rst_pulses", FW'(n_valid - v0), FW'(1));
    check("mid_rst_no_err", FW'(n_ferr - f0),  FW'(0));

`ifdef LAYER_DESER_TIMEOUT_EN
    // Timeout: 4 words then 8 idle cycles aborts the frame.
    f_prev = frame_of(16'hA000);
    v0 = n_valid;
    f0 = n_ferr;
    for (int i = 0; i < 4; i++) send_word(DW'(16'hC000 + i));
    idle(TO - 1);
    check("to_not_yet_err",  FW'(frame_err), FW'(0));
    check("to_not_yet_busy", FW'(busy),      FW'(1));
    idle(1);
    check("to_err",       FW'(frame_err), FW'(1));
    check("to_busy_fell", FW'(busy),      FW'(0));
    check("to_no_valid",  FW'(out_valid), FW'(0));
    check("to_data_kept", out_data, f_prev);
    idle(1);
    check("to_err_1cyc", FW'(frame_err), FW'(0));
    for (int i = 0; i < NW; i++) send_word(DW'(16'hD000 + i));
    check("to_next_valid", FW'(out_valid), FW'(1));
    check("to_next_frame", out_data, frame_of(16'hD000));

    // Word arrives on what would be the 8th idle cycle: no timeout.
    for (int i = 0; i < 4; i++) send_word(DW'(16'hE000 + i));
    idle(TO - 1);
    for (int i = 4; i < NW; i++) send_word(DW'(16'hE000 + i));
    check("to_save_valid", FW'(out_valid), FW'(1));
    check("to_save_frame", out_data, frame_of(16'hE000));
    idle(2);
    check("to_err_pulses",   FW'(n_ferr - f0),  FW'(1));
    check("to_valid_pulses", FW'(n_valid - v0), FW'(2));
`else
    // Without the timeout a long gap simply waits; frame_err never rises.
    f0 = n_ferr;
    for (int i = 0; i < 4; i++) send_word(DW'(16'hC000 + i));
    idle(100);
    check("noto_busy_held", FW'(busy), FW'(1));
    for (int i = 4; i < NW; i++) send_word(DW'(16'hC000 + i));
    check("noto_frame", out_data, frame_of(16'hC000));
    idle(1);
    check("noto_no_err", FW'(n_ferr - f0), FW'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
